// File: rtl/icache_refill_responder.sv
// icache_refill_responder: fetches one word for an I-cache miss and
// returns the set line with the victim way refilled.
//
// Ports:
//   CLK, RESET (async, active-low)
//   req_valid/req_addr/req_mode/req_line : miss request + set snapshot
//   busy                                 : high whenever not IDLE
//   mem_rd_valid/mem_rd_addr/mem_rd_ready: backing read request
//   mem_rsp_valid/mem_rsp_data/mem_rsp_err: backing read response
//   fill_line/fill_valid/fill_err        : refill result to the cache
//
// Optional: define ICACHE_REFILL_TIMEOUT_EN to abort a refill after
// TIMEOUT_CYCLES cycles in MEM_REQ/MEM_WAIT with a fill_err pulse.

module icache_refill_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_W           = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         req_valid,
   input  logic [31:0]  req_addr,
   input  logic [1:0]   req_mode,
   input  logic [108:0] req_line,
   output logic         busy,
   output logic         mem_rd_valid,
   output logic [31:0]  mem_rd_addr,
   input  logic         mem_rd_ready,
   input  logic         mem_rsp_valid,
   input  logic [31:0]  mem_rsp_data,
   input  logic         mem_rsp_err,
   output logic [108:0] fill_line,
   output logic         fill_valid,
   output logic         fill_err
);

   typedef enum logic [1:0] {
      IDLE,
      MEM_REQ,
      MEM_WAIT,
      RESP
   } state_t;

   state_t       state_q;
   state_t       state_d;
   logic [108:0] line_q;
   logic [31:0]  data_q;
   logic         rr_q;

   logic         accept;
   logic         capture;
   logic         fill_d;
   logic         err_d;
   logic         expired;
   logic         both_v;
   logic         vict1;
   logic [19:0]  tag;
   logic [108:0] merged;

   // Byte offset within the word never matters for a word fetch.
   logic         unused_addr_lsb;
   assign unused_addr_lsb = ^req_addr[1:0];

   if (2 ** TO_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
      $error("TO_W too narrow for TIMEOUT_CYCLES");
   end

   // The latched read address doubles as the stored miss tag.
   assign tag = mem_rd_addr[31:12];

`ifdef ICACHE_REFILL_TIMEOUT_EN
   logic [TO_W-1:0] to_q;

   assign expired = (state_q == MEM_REQ || state_q == MEM_WAIT) &&
                    (to_q == TO_W'(TIMEOUT_CYCLES));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         to_q <= '0;
      end else if (accept) begin
         to_q <= '0;
      end else if (state_q == MEM_REQ || state_q == MEM_WAIT) begin
         to_q <= to_q + 1'b1;
      end
   end
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      fill_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid && req_mode == 2'b01) begin
               accept  = 1'b1;
               state_d = MEM_REQ;
            end
         end
         MEM_REQ: begin
            if (mem_rd_ready) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (mem_rsp_valid) begin
               if (mem_rsp_err) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  capture = 1'b1;
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            fill_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Expiry beats a response landing in the same cycle.
      if (expired) begin
         capture = 1'b0;
         err_d   = 1'b1;
         state_d = IDLE;
      end
   end

   // Victim: empty way0, else empty way1, else round-robin toggle.
   always_comb begin
      both_v = line_q[53] & line_q[108];
      vict1  = line_q[53] & (~line_q[108] | rr_q);
      merged = line_q;
      if (vict1) begin
         merged[108:54] = {1'b1, 2'b00, tag, data_q};
      end else begin
         merged[53:0] = {1'b1, 1'b0, tag, data_q};
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q      <= IDLE;
         busy         <= 1'b0;
         mem_rd_valid <= 1'b0;
         mem_rd_addr  <= '0;
         fill_line    <= '0;
         fill_valid   <= 1'b0;
         fill_err     <= 1'b0;
         line_q       <= '0;
         data_q       <= '0;
         rr_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy         <= (state_d != IDLE);
         mem_rd_valid <= (state_d == MEM_REQ);
         fill_valid   <= fill_d;
         fill_err     <= err_d;
         if (accept) begin
            mem_rd_addr <= {req_addr[31:2], 2'b00};
            line_q      <= req_line;
         end
         if (capture) data_q <= mem_rsp_data;
         if (fill_d) begin
            fill_line <= merged;
            if (both_v) rr_q <= ~rr_q;
         end
      end
   end

endmodule

// File: doc/icache_refill_responder.md
# icache_refill_responder

Memory-side responder for the instruction cache miss interface. Accepts a miss request (address plus the 109-bit two-way line snapshot read at that set), fetches one 32-bit word over a valid/ready backing-memory read bus, and merges it into the victim way. It returns the completed line with a one-cycle write pulse that the cache writes straight into its set RAM. It sits between the instruction cache and the instruction memory port.

## Interface
- TIMEOUT_CYCLES, 255: watchdog limit in cycles. Only used with ICACHE_REFILL_TIMEOUT_EN.
- TO_W, 8: watchdog counter width. Must satisfy 2^TO_W > TIMEOUT_CYCLES.
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- req_valid  in  1  miss request from the cache
- req_addr  in  32  miss address
- req_mode  in  2  request type; only 2'b01 (instruction fetch) is honoured
- req_line  in  109  current set contents. Way1: [108] valid, [107:106] reserved, [105:86] tag, [85:54] data. Way0: [53] valid, [52] reserved, [51:32] tag, [31:0] data.
- busy  out  1  high in every state except IDLE
- mem_rd_valid  out  1  backing read request
- mem_rd_addr  out  32  word-aligned read address {req_addr[31:2],2'b00}
- mem_rd_ready  in  1  backing memory accepts the request
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  32  read data
- mem_rsp_err  in  1  bus error, qualified by mem_rsp_valid
- fill_line  out  109  merged line to write into the cache
- fill_valid  out  1  one-cycle write strobe for fill_line
- fill_err  out  1  one-cycle refill failure pulse

## Operation
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP.
- IDLE:
  - A request is accepted when req_valid=1 and req_mode=2'b01.
  - On acceptance, req_addr and req_line are latched and the FSM moves to MEM_REQ.
  - A request with any other req_mode is ignored silently.
- MEM_REQ:
  - mem_rd_valid=1 and mem_rd_addr is held stable.
  - When mem_rd_valid & mem_rd_ready, the FSM moves to MEM_WAIT and mem_rd_valid drops on the next cycle.
- MEM_WAIT:
  - The first mem_rsp_valid is captured.
  - If err=0, the merged line is built and the FSM moves to RESP.
  - If err=1, fill_err pulses and the FSM returns to IDLE.
- RESP: fill_valid=1 for exactly one cycle, then the FSM returns to IDLE.
- Victim selection, in priority order:
  1. If way0 is invalid, way0.
  2. Otherwise, if way1 is invalid, way1.
  3. Otherwise, the way given by the replacement toggle rr (0 selects way0). rr flips only on a successful fill where both ways were valid.
- Merge:
  - The victim half gets valid=1, reserved bits=0, tag=req_addr[31:12], data=mem_rsp_data.
  - The non-victim half is copied unchanged from the latched req_line.
- Requests arriving while busy=1 are dropped; the cache re-requests after fill.
- mem_rsp_valid outside MEM_WAIT (stale or late data) is ignored.

## Timing
- Reset values: busy, mem_rd_valid, fill_valid, fill_err = 0; mem_rd_addr, fill_line = 0; rr=0; FSM in IDLE.
- All outputs are registered.
- Minimum latency:
  - Request sampled at edge t.
  - mem_rd_valid=1 after t.
  - With ready already high, handshake at t+1.
  - Response sampled at t+2.
  - fill_valid high in the cycle after edge t+3.
  - Total 3 cycles.
- fill_line holds its value until the next fill. It is valid whenever fill_valid=1.
- A response in the same cycle as the request handshake is ignored, because the FSM is still in MEM_REQ.
- Assertion of RESET mid-operation:
  - The FSM returns to IDLE immediately and asynchronously.
  - mem_rd_valid drops.
  - Any later response is ignored.
- fill_valid and fill_err are never high in the same cycle.

## Configuration
- ICACHE_REFILL_TIMEOUT_EN defined:
  - A TO_W-bit counter clears on entry to MEM_REQ and increments every cycle in MEM_REQ or MEM_WAIT.
  - When the count equals TIMEOUT_CYCLES, the FSM returns to IDLE, mem_rd_valid drops and fill_err pulses once.
  - A response landing in the expiry cycle loses to the timeout.
- Not defined: no counter exists; the FSM waits in MEM_REQ/MEM_WAIT indefinitely.

## Test plan
- Miss on an empty set. Stimulus: req_addr=0x0000_1234, req_line=0, ready=1, rsp data 0xDEADBEEF after 1 cycle. Required: mem_rd_addr=0x0000_1234; fill_line[53]=1, [51:32]=0x00001, [31:0]=0xDEADBEEF, upper half all 0; fill_valid one cycle at 3-cycle latency.
- Way0 valid, way1 invalid. Required: way1 filled, way0 bits [53:0] copied unchanged.
- Both ways valid, two successive fills. Required: first fill replaces way0, second replaces way1 (rr toggles).
- mem_rsp_err=1 on response. Required: fill_err pulse, no fill_valid, busy low next cycle.
- Busy-state drops and bad mode:
  - req_valid held high while busy: exactly one mem_rd_valid handshake.
  - req_mode=2'b10 in IDLE: no bus activity.
- Timeout, with ICACHE_REFILL_TIMEOUT_EN and TIMEOUT_CYCLES=8: no response for 8 cycles -> fill_err pulse, FSM in IDLE; a late response 5 cycles later -> ignored. Reset asserted in MEM_WAIT -> all outputs 0 immediately.
